fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-issue side of the control decoder: owns the PC, reads the 8-bit instruction ROM and presents each instruction to the decoder.
- Consumes the decoder's registered branchf/branchb/done outputs to choose the next PC.
- Multicycle sequencer, one instruction in flight, four clocks per instruction; halts permanently on done until reset.

Parameters:
- PC_WIDTH, 8, width of PC and ROM address.
- INSTR_WIDTH, 8, instruction width; must equal decoder instruction width.
- CNT_WIDTH, 16, width of the instruction and cycle counters.

Ports:
- clock_i  in  1  system clock, all state on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  level; leaving IDLE requires start_i=1.
- imem_addr_o  out  PC_WIDTH  ROM read address; ROM returns data one clock later.
- imem_data_i  in  INSTR_WIDTH  ROM read data.
- instruction_o  out  INSTR_WIDTH  registered instruction to decoder instruction_i.
- branchf_i  in  1  decoder forward-branch-taken.
- branchb_i  in  1  decoder backward-branch-taken.
- done_i  in  1  decoder halt indication.
- offset_i  in  PC_WIDTH  unsigned branch distance (register-file read data of rs).
- pc_o  out  PC_WIDTH  current PC.
- running_o  out  1  high in FETCH/LATCH/DECODE/EXEC.
- done_o  out  1  high in HALTED.
- error_o  out  1  sticky; both branch inputs seen high in EXEC.
- instr_count_o  out  CNT_WIDTH  retired instructions, saturating.
- cycle_count_o  out  CNT_WIDTH  clocks spent running, saturating.

Behaviour:
- Reset (reset_i=1 at an edge, wins over everything, legal in any state): state=IDLE, pc=0, imem_addr_o=0, instruction_o=0, done_o=0, running_o=0, error_o=0, both counters=0.
- States: IDLE, FETCH, LATCH, DECODE, EXEC, HALTED; 3-bit encoding.
- Each of FETCH, LATCH, DECODE and EXEC lasts exactly one clock.
- IDLE: wait for start_i; then go to FETCH.
- FETCH: imem_addr_o=pc; go to LATCH.
- LATCH: at the end of the cycle, instruction_o<=imem_data_i; go to DECODE.
- DECODE: instruction_o stable; the decoder registers its outputs at the end of this cycle; go to EXEC.
- EXEC: sample done_i, branchf_i, branchb_i, offset_i. Priority, first match wins:
  - done_i=1: pc unchanged, go to HALTED.
  - branchf_i=1 and branchb_i=1: error_o<=1, pc<=pc+1, go to FETCH.
  - branchf_i=1: pc<=pc+offset_i, go to FETCH.
  - branchb_i=1: pc<=pc-offset_i, go to FETCH.
  - otherwise: pc<=pc+1, go to FETCH.
- EXEC increments instr_count_o in every case, including the halting instruction.
- PC arithmetic is modulo 2^PC_WIDTH, with silent wrap:
  - 0xFF+1 yields 0x00.
  - 0x02-0x05 yields 0xFD.
  - offset 0 gives a self-loop.
- HALTED: done_o=1, running_o=0, pc and instruction_o hold. Only reset exits HALTED; start_i is ignored. The decoder's done is sticky, so this matches it.
- cycle_count_o increments once per clock in FETCH/LATCH/DECODE/EXEC and saturates at all-ones.
- instr_count_o saturates at all-ones.
- start_i is ignored outside IDLE; deasserting it mid-run has no effect.
- done_i, branchf_i and branchb_i are ignored outside EXEC. Garbage from the previous instruction is never acted on.
- Reset mid-operation discards the in-flight instruction; no partial PC update occurs.
- Throughput: 1 instruction per 4 clocks. The first ROM address appears the clock after start_i is sampled.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state enum/localparams for fetch_unit;
  - opcode localparams (AND 00, ADD 01, SET 110, SLL 11100, SRL 11101, BRF 11110, SUBS 11111, SLT 10000, HALT 10001, LOAD 10010, STORE 10011, ABS 10100, SEQ 10101, BRB 10110);
  - INSTR_WIDTH.
- One sub-module: sat_counter (parameter width, enable, sync reset, saturate), instantiated twice for the counters.
- The PC/next-PC mux and the FSM stay in fetch_unit.

Test Plan:
- Reset/idle: assert reset_i 2 clocks, hold start_i=0 for 10 clocks -> pc_o=0, running_o=0, done_o=0, cycle_count_o=0, imem_addr_o=0.
- Straight-line: ROM[0..2]=ADD, AND, HALT (0x50,0x08,0x88) with a real decoder, start_i=1 for 1 clock -> imem_addr_o sequence 0,1,2; done_o rises 12 clocks after start sampled; instr_count_o=3; cycle_count_o=12; pc_o=2.
- Branch forward/back: force branchf_i=1, offset_i=5 in EXEC at pc=3 -> next fetch address 8. Force branchb_i=1, offset_i=6 at pc=8 -> next address 2.
- Wrap: pc=0xFE, two sequential instructions -> addresses 0xFE, 0xFF, 0x00. branchb_i with offset 0x05 at pc=0x02 -> 0xFD.
- Conflict and ignored inputs:
  - both branch inputs high in EXEC at pc=4 -> error_o=1 (stays 1), next address 5;
  - branchf_i pulsed during DECODE -> no PC effect.
- Reset mid-run and halt lock:
  - reset_i during DECODE -> next cycle IDLE, pc_o=0, error_o=0;
  - in HALTED, start_i=1 for 5 clocks -> stays HALTED.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: fetch sequencer states, instruction opcodes and widths.
package ctrl_pkg;

  localparam int unsigned INSTR_WIDTH = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StLatch  = 3'd2,
    StDecode = 3'd3,
    StExec   = 3'd4,
    StHalted = 3'd5
  } fetch_state_e;

  // Opcodes are left-aligned in the instruction; their lengths vary.
  localparam logic [1:0] OpAnd   = 2'b00;
  localparam logic [1:0] OpAdd   = 2'b01;
  localparam logic [2:0] OpSet   = 3'b110;
  localparam logic [4:0] OpSll   = 5'b11100;
  localparam logic [4:0] OpSrl   = 5'b11101;
  localparam logic [4:0] OpBrf   = 5'b11110;
  localparam logic [4:0] OpSubs  = 5'b11111;
  localparam logic [4:0] OpSlt   = 5'b10000;
  localparam logic [4:0] OpHalt  = 5'b10001;
  localparam logic [4:0] OpLoad  = 5'b10010;
  localparam logic [4:0] OpStore = 5'b10011;
  localparam logic [4:0] OpAbs   = 5'b10100;
  localparam logic [4:0] OpSeq   = 5'b10101;
  localparam logic [4:0] OpBrb   = 5'b10110;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Multicycle instruction fetch sequencer: owns the PC, reads the ROM, and picks the next PC
// from the decoder's registered branch/halt outputs. One instruction every four clocks.
module fetch_unit #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = ctrl_pkg::INSTR_WIDTH,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_data_i,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  input  logic                   branchf_i,
  input  logic                   branchb_i,
  input  logic                   done_i,
  input  logic [PC_WIDTH-1:0]    offset_i,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic                   running_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [CNT_WIDTH-1:0]   instr_count_o,
  output logic [CNT_WIDTH-1:0]   cycle_count_o
);

  import ctrl_pkg::*;

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   error_q, error_d;
  logic                   running;
  logic                   retire;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    error_d = error_q;
    retire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        instr_d = imem_data_i;
        state_d = StDecode;
      end
      StDecode: state_d = StExec;
      StExec: begin
        retire  = 1'b1;
        state_d = StFetch;
        // PC arithmetic wraps silently at PC_WIDTH bits.
        if (done_i) begin
          state_d = StHalted;
        end else if (branchf_i && branchb_i) begin
          error_d = 1'b1;
          pc_d    = pc_q + PC_WIDTH'(1);
        end else if (branchf_i) begin
          pc_d = pc_q + offset_i;
        end else if (branchb_i) begin
          pc_d = pc_q - offset_i;
        end else begin
          pc_d = pc_q + PC_WIDTH'(1);
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  assign running = (state_q == StFetch) || (state_q == StLatch) ||
                   (state_q == StDecode) || (state_q == StExec);

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_instr_count (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .en_i    (retire),
    .count_o (instr_count_o)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cycle_count (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .en_i    (running),
    .count_o (cycle_count_o)
  );

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instruction_o = instr_q;
  assign running_o     = running;
  assign done_o        = (state_q == StHalted);
  assign error_o       = error_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM and halt-decoder models, expected fetch addresses queued.
module tb_fetch_unit;

  import ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  imem_addr;
  logic [7:0]  imem_data;
  logic [7:0]  instruction;
  logic        branchf, branchb, done_in;
  logic [7:0]  offset;
  logic [7:0]  pc;
  logic        running, done_out, error;
  logic [15:0] instr_count, cycle_count;

  logic        frc_bf, frc_bb, frc_done, dec_done;
  logic [7:0]  rom [256];
  logic [7:0]  exp_q [$];
  logic [7:0]  model_pc;
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  fetch_unit #(
    .PC_WIDTH    (8),
    .INSTR_WIDTH (8),
    .CNT_WIDTH   (16)
  ) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .start_i       (start),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .instruction_o (instruction),
    .branchf_i     (branchf),
    .branchb_i     (branchb),
    .done_i        (done_in),
    .offset_i      (offset),
    .pc_o          (pc),
    .running_o     (running),
    .done_o        (done_out),
    .error_o       (error),
    .instr_count_o (instr_count),
    .cycle_count_o (cycle_count)
  );

  // ROM with one clock of read latency.
  always @(posedge clock) imem_data <= rom[imem_addr];

  // Minimal decoder stand-in: registered, sticky halt detection.
  always @(posedge clock) begin
    if (reset) dec_done <= 1'b0;
    else if (instruction[7:3] == OpHalt) dec_done <= 1'b1;
  end

  assign done_in = dec_done | frc_done;
  assign branchf = frc_bf;
  assign branchb = frc_bb;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Called in a FETCH cycle: the presented address must be the oldest expected one.
  task automatic fetch_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 32'(imem_addr), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(imem_addr), 32'(e));
      model_pc = e;
    end
  endtask

  task automatic instr(input string tag, input logic bf, input logic bb, input logic [7:0] off,
                       input logic pulse_dec);
    logic [7:0] nxt;
    fetch_check(tag);
    tick;
    tick;
    if (pulse_dec) frc_bf = 1'b1;
    tick;
    frc_bf = bf;
    frc_bb = bb;
    offset = off;
    if (bf && bb)  nxt = model_pc + 8'd1;
    else if (bf)   nxt = model_pc + off;
    else if (bb)   nxt = model_pc - off;
    else           nxt = model_pc + 8'd1;
    exp_q.push_back(nxt);
    tick;
    frc_bf = 1'b0;
    frc_bb = 1'b0;
    offset = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    reset    = 1'b1;
    start    = 1'b0;
    frc_bf   = 1'b0;
    frc_bb   = 1'b0;
    frc_done = 1'b0;
    offset   = 8'h00;
    model_pc = 8'h00;

    tick;
    tick;
    reset = 1'b0;
    repeat (10) tick;
    chk("idle_pc", 32'(pc), 32'h0);
    chk("idle_running", 32'(running), 32'h0);
    chk("idle_done", 32'(done_out), 32'h0);
    chk("idle_cycles", 32'(cycle_count), 32'h0);
    chk("idle_addr", 32'(imem_addr), 32'h0);
    chk("idle_instr", 32'(instruction), 32'h0);
    chk("idle_error", 32'(error), 32'h0);
    chk("idle_icount", 32'(instr_count), 32'h0);

    // Branches, wrap-around and conflicting branch inputs.
    start = 1'b1;
    exp_q.push_back(8'h00);
    tick;
    start = 1'b0;
    chk("run_running", 32'(running), 32'h1);
    instr("seq_pc0", 1'b0, 1'b0, 8'h00, 1'b0);
    instr("seq_pc1", 1'b0, 1'b0, 8'h00, 1'b0);
    instr("seq_pc2", 1'b0, 1'b0, 8'h00, 1'b0);
    instr("brf_pc3", 1'b1, 1'b0, 8'h05, 1'b0);
    instr("brb_pc8", 1'b0, 1'b1, 8'h06, 1'b0);
    instr("brb_wrap_pc2", 1'b0, 1'b1, 8'h05, 1'b0);
    instr("wrap_pcfd", 1'b0, 1'b0, 8'h00, 1'b0);
    instr("wrap_pcfe", 1'b0, 1'b0, 8'h00, 1'b0);
    instr("wrap_pcff", 1'b0, 1'b0, 8'h00, 1'b0);
    instr("wrap_pc00", 1'b0, 1'b0, 8'h00, 1'b0);
    instr("seq_pc1b", 1'b0, 1'b0, 8'h00, 1'b0);
    instr("seq_pc2b", 1'b0, 1'b0, 8'h00, 1'b0);
    instr("seq_pc3b", 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre_conflict_error", 32'(error), 32'h0);
    instr("conflict_pc4", 1'b1, 1'b1, 8'h09, 1'b0);
    chk("conflict_error", 32'(error), 32'h1);
    instr("decpulse_pc5", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("error_sticky", 32'(error), 32'h1);
    chk("mid_icount", 32'(instr_count), 32'd15);
    chk("mid_cycles", 32'(cycle_count), 32'd60);

    // Reset while an instruction is in DECODE.
    fetch_check("pc6_before_reset");
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_icount", 32'(instr_count), 32'h0);
    tick;
    tick;
    chk("rst_stays_idle", 32'(running), 32'h0);
    exp_q.delete();

    // Straight-line program ending in HALT.
    rom[0] = 8'h50;
    rom[1] = 8'h08;
    rom[2] = 8'h88;
    start = 1'b1;
    exp_q.push_back(8'h00);
    tick;
    start = 1'b0;
    instr("prog_pc0", 1'b0, 1'b0, 8'h00, 1'b0);
    instr("prog_pc1", 1'b0, 1'b0, 8'h00, 1'b0);
    fetch_check("prog_pc2");
    tick;
    tick;
    tick;
    chk("halt_instr", 32'(instruction), 32'h88);
    chk("halt_done_early", 32'(done_out), 32'h0);
    tick;
    chk("halt_done", 32'(done_out), 32'h1);
    chk("halt_running", 32'(running), 32'h0);
    chk("halt_icount", 32'(instr_count), 32'd3);
    chk("halt_cycles", 32'(cycle_count), 32'd12);
    chk("halt_pc", 32'(pc), 32'h2);

    start = 1'b1;
    repeat (5) tick;
    start = 1'b0;
    chk("lock_done", 32'(done_out), 32'h1);
    chk("lock_running", 32'(running), 32'h0);
    chk("lock_pc", 32'(pc), 32'h2);
    chk("lock_cycles", 32'(cycle_count), 32'd12);
    chk("lock_instr", 32'(instruction), 32'h88);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
